// File: rtl/cart_bus_arb_if.sv
// Cartridge bus arbiter signal bundle: requester-side channels plus the single cart port.
// Handshake: a requester holds req_rd/req_wr (with addr/din) as "valid" until its req_ack pulses;
// req_ack is the one-cycle completion ("ready"), and req_err qualifies that same pulse on timeout.
// On the cart side cart_rd/cart_wr are one-cycle strobes; cart_busy rising then falling marks completion.
interface cart_bus_arb_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req_rd;
   logic [NUM_REQ-1:0]        req_wr;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_din;
   logic [DATA_W-1:0]         req_dout;
   logic [NUM_REQ-1:0]        req_ack;
   logic [NUM_REQ-1:0]        req_err;
   logic                      force_en;
   logic [2:0]                force_sel;
   logic [ADDR_W-1:0]         cart_addr;
   logic [DATA_W-1:0]         cart_din;
   logic                      cart_rd;
   logic                      cart_wr;
   logic [DATA_W-1:0]         cart_dout;
   logic                      cart_busy;

   modport slave (
      input  req_rd, req_wr, req_addr, req_din, force_en, force_sel, cart_dout, cart_busy,
      output req_dout, req_ack, req_err, cart_addr, cart_din, cart_rd, cart_wr
   );

   modport master (
      output req_rd, req_wr, req_addr, req_din, force_en, force_sel, cart_dout, cart_busy,
      input  req_dout, req_ack, req_err, cart_addr, cart_din, cart_rd, cart_wr
   );
endinterface

// File: rtl/cart_bus_arb.sv
// N-channel latched arbiter for the cartridge bus: round-robin or fixed priority,
// exclusive force mode and a busy timeout so a stuck cart cannot hang the bus.
module cart_bus_arb #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int RR_MODE = 1,
   parameter int TIMEOUT = 255
) (
   input  logic             clk_8m,
   input  logic             rst,
   cart_bus_arb_if.slave    bus,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // The counter only ever needs to hold 0..TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_last;
   logic                r_op_wr;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_din;
   logic                r_rd;
   logic                r_wr;
   logic [DATA_W-1:0]   r_dout;
   logic [NUM_REQ-1:0]  r_ack;
   logic [NUM_REQ-1:0]  r_err;
   logic [CNT_W-1:0]    r_cnt;

   logic [NUM_REQ-1:0]  w_req;
   logic [NUM_REQ-1:0]  w_elig;
   logic                w_found;
   logic [IDX_W-1:0]    w_pick;
   logic                w_pick_wr;
   logic [ADDR_W-1:0]   w_pick_addr;
   logic [DATA_W-1:0]   w_pick_din;
   logic [NUM_REQ-1:0]  w_gnt_oh;
   logic                w_timeout;
   logic                w_grant;
   logic                w_clr_cnt;
   logic                w_done;
   logic                w_err;
   logic                w_cap;

   // Force mode narrows eligibility to one requester; an out-of-range index leaves nobody eligible.
   always_comb begin
      w_req  = bus.req_rd | bus.req_wr;
      w_elig = w_req;
      if (bus.force_en) begin
         w_elig = '0;
         if (int'(bus.force_sel) < NUM_REQ) begin
            w_elig[IDX_W'(bus.force_sel)] = w_req[IDX_W'(bus.force_sel)];
         end
      end
   end

   always_comb begin
      int v_start;
      int v_idx;
      w_found = 1'b0;
      w_pick  = '0;
      v_start = (RR_MODE != 0) ? (int'(r_last) + 1) % NUM_REQ : 0;
      v_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = (v_start + k) % NUM_REQ;
         if (!w_found && w_elig[IDX_W'(v_idx)]) begin
            w_found = 1'b1;
            w_pick  = IDX_W'(v_idx);
         end
      end
   end

   assign w_pick_wr   = bus.req_wr[w_pick];
   assign w_pick_addr = bus.req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
   assign w_pick_din  = bus.req_din[int'(w_pick)*DATA_W +: DATA_W];

   always_comb begin
      w_gnt_oh         = '0;
      w_gnt_oh[r_last] = 1'b1;
   end

   assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

   always_ff @(posedge clk_8m) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_clr_cnt   = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_cap       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_grant     = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_clr_cnt   = 1'b1;
            w_state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (bus.cart_busy) begin
               w_clr_cnt   = 1'b1;
               w_state_nxt = S_WAIT_DONE;
            end else if (w_timeout) begin
               w_done      = 1'b1;
               w_err       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            // A normal completion wins over a timeout landing on the same cycle.
            if (!bus.cart_busy) begin
               w_done      = 1'b1;
               w_cap       = !r_op_wr;
               w_state_nxt = S_IDLE;
            end else if (w_timeout) begin
               w_done      = 1'b1;
               w_err       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_8m) begin
      if (rst) begin
         r_last  <= LAST_RST;
         r_op_wr <= 1'b0;
         r_addr  <= '0;
         r_din   <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_dout  <= '0;
         r_ack   <= '0;
         r_err   <= '0;
         r_cnt   <= '0;
      end else begin
         r_rd  <= w_grant & ~w_pick_wr;
         r_wr  <= w_grant & w_pick_wr;
         r_ack <= w_done ? w_gnt_oh : '0;
         r_err <= w_err ? w_gnt_oh : '0;
         // r_last doubles as the grant index of the transaction in flight.
         if (w_grant) begin
            r_last  <= w_pick;
            r_op_wr <= w_pick_wr;
            r_addr  <= w_pick_addr;
            r_din   <= w_pick_din;
         end
         if (w_cap) begin
            r_dout <= bus.cart_dout;
         end
         if (w_clr_cnt) begin
            r_cnt <= '0;
         end else if ((TIMEOUT != 0) &&
                      ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE))) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.cart_rd   = r_rd;
   assign bus.cart_wr   = r_wr;
   assign bus.cart_addr = r_addr;
   assign bus.cart_din  = r_din;
   assign bus.req_dout  = r_dout;
   assign bus.req_ack   = r_ack;
   assign bus.req_err   = r_err;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cart_bus_arb.sv
// Directed bench for cart_bus_arb: a round-robin instance (a) and a fixed-priority instance (b),
// each with a behavioural cart and a scoreboard of expected strobes and acks.
module tb_cart_bus_arb;

   logic clk_8m = 1'b0;
   logic rst;
   logic [1:0] a_state;
   logic [1:0] b_state;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   cart_bus_arb_if #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(8)) a ();
   cart_bus_arb_if #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(8)) b ();

   cart_bus_arb #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(8), .RR_MODE(1), .TIMEOUT(10)) dut_a (
      .clk_8m      (clk_8m),
      .rst         (rst),
      .bus         (a),
      .o_dbg_state (a_state)
   );

   cart_bus_arb #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(8), .RR_MODE(0), .TIMEOUT(10)) dut_b (
      .clk_8m      (clk_8m),
      .rst         (rst),
      .bus         (b),
      .o_dbg_state (b_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_8m = ~clk_8m;
   always @(posedge clk_8m) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   // strobe entry: {wr, rd, addr[15:0], din[7:0]}; ack entry: {err[2:0], ack[2:0], dout[7:0]}
   logic [25:0] a_sq[$];
   logic [13:0] a_aq[$];
   logic [25:0] b_sq[$];
   logic [13:0] b_aq[$];
   int a_last_sc = 0;
   int a_prev_sc = 0;

   int   a_busy_len = 4;
   logic [7:0] a_cart_data = 8'h00;
   logic a_stuck = 1'b0;
   int   b_busy_len = 2;
   logic [7:0] b_cart_data = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural cart: busy rises the edge after a strobe and stays high busy_len cycles.
   initial begin
      a.cart_busy = 1'b0;
      a.cart_dout = 8'h00;
      forever begin
         @(posedge clk_8m);
         if (!a_stuck && (a.cart_rd || a.cart_wr)) begin
            #1;
            a.cart_busy = 1'b1;
            a.cart_dout = a_cart_data;
            repeat (a_busy_len) @(posedge clk_8m);
            #1;
            a.cart_busy = 1'b0;
         end
      end
   end

   initial begin
      b.cart_busy = 1'b0;
      b.cart_dout = 8'h00;
      forever begin
         @(posedge clk_8m);
         if (b.cart_rd || b.cart_wr) begin
            #1;
            b.cart_busy = 1'b1;
            b.cart_dout = b_cart_data;
            repeat (b_busy_len) @(posedge clk_8m);
            #1;
            b.cart_busy = 1'b0;
         end
      end
   end

   always @(negedge clk_8m) begin
      if (a.cart_rd || a.cart_wr) begin
         a_prev_sc = a_last_sc;
         a_last_sc = cyc;
         n_vec++;
         assert (a_sq.size() != 0) else begin
            n_err++;
            $error("FAIL a_strobe: unexpected strobe at addr %0h, required none", a.cart_addr);
         end
         if (a_sq.size() != 0)
            check("a_strobe", {6'd0, a.cart_wr, a.cart_rd, a.cart_addr, a.cart_din}, {6'd0, a_sq.pop_front()});
      end
      if ((|a.req_ack) || (|a.req_err)) begin
         n_vec++;
         assert (a_aq.size() != 0) else begin
            n_err++;
            $error("FAIL a_ack: unexpected ack %0b err %0b, required none", a.req_ack, a.req_err);
         end
         if (a_aq.size() != 0)
            check("a_ack", {18'd0, a.req_err, a.req_ack, a.req_dout}, {18'd0, a_aq.pop_front()});
      end
   end

   always @(negedge clk_8m) begin
      if (b.cart_rd || b.cart_wr) begin
         n_vec++;
         assert (b_sq.size() != 0) else begin
            n_err++;
            $error("FAIL b_strobe: unexpected strobe at addr %0h, required none", b.cart_addr);
         end
         if (b_sq.size() != 0)
            check("b_strobe", {6'd0, b.cart_wr, b.cart_rd, b.cart_addr, b.cart_din}, {6'd0, b_sq.pop_front()});
      end
      if ((|b.req_ack) || (|b.req_err)) begin
         n_vec++;
         assert (b_aq.size() != 0) else begin
            n_err++;
            $error("FAIL b_ack: unexpected ack %0b err %0b, required none", b.req_ack, b.req_err);
         end
         if (b_aq.size() != 0)
            check("b_ack", {18'd0, b.req_err, b.req_ack, b.req_dout}, {18'd0, b_aq.pop_front()});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic a_req(input logic [1:0] i, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [7:0] din);
      a.req_rd[i] = rd;
      a.req_wr[i] = wr;
      a.req_addr[i*16 +: 16] = addr;
      a.req_din[i*8 +: 8] = din;
   endtask

   task automatic b_req(input logic [1:0] i, input logic rd, input logic [15:0] addr);
      b.req_rd[i] = rd;
      b.req_addr[i*16 +: 16] = addr;
   endtask

   task automatic a_exp_strobe(input logic wr, input logic rd, input logic [15:0] addr, input logic [7:0] din);
      a_sq.push_back({wr, rd, addr, din});
   endtask

   task automatic a_exp_ack(input logic [2:0] err, input logic [2:0] ack, input logic [7:0] dout);
      a_aq.push_back({err, ack, dout});
   endtask

   task automatic wait_a_ack(input logic [1:0] idx, input int max_cyc, input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < max_cyc && !seen; k++) begin
         @(negedge clk_8m);
         if (a.req_ack[idx]) seen = 1'b1;
      end
      n_vec++;
      assert (seen) else begin
         n_err++;
         $error("FAIL %s: ack[%0d] observed none within %0d cycles, required one", tag, idx, max_cyc);
      end
   endtask

   task automatic wait_a_state(input logic [1:0] st, input int max_cyc, input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < max_cyc && !seen; k++) begin
         @(negedge clk_8m);
         if (a_state == st) seen = 1'b1;
      end
      n_vec++;
      assert (seen) else begin
         n_err++;
         $error("FAIL %s: state observed %0d, required %0d within %0d cycles", tag, a_state, st, max_cyc);
      end
   endtask

   task automatic wait_a_strobe(input int max_cyc, input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < max_cyc && !seen; k++) begin
         @(negedge clk_8m);
         if (a.cart_rd || a.cart_wr) seen = 1'b1;
      end
      n_vec++;
      assert (seen) else begin
         n_err++;
         $error("FAIL %s: strobe observed none within %0d cycles, required one", tag, max_cyc);
      end
   endtask

   task automatic do_reset();
      @(posedge clk_8m);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk_8m);
      #1 rst = 1'b0;
   endtask

   task automatic check_a_reset(input string tag);
      check({tag, "_rd"},    a.cart_rd,   0);
      check({tag, "_wr"},    a.cart_wr,   0);
      check({tag, "_addr"},  a.cart_addr, 0);
      check({tag, "_din"},   a.cart_din,  0);
      check({tag, "_dout"},  a.req_dout,  0);
      check({tag, "_ack"},   a.req_ack,   0);
      check({tag, "_err"},   a.req_err,   0);
      check({tag, "_state"}, a_state,     0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int got;
      int wb_cyc;
      rst = 1'b1;
      a.req_rd = '0; a.req_wr = '0; a.req_addr = '0; a.req_din = '0;
      a.force_en = 1'b0; a.force_sel = 3'd0;
      b.req_rd = '0; b.req_wr = '0; b.req_addr = '0; b.req_din = '0;
      b.force_en = 1'b0; b.force_sel = 3'd0;

      do_reset();
      @(negedge clk_8m);
      check_a_reset("rst0");
      check("rst0_b_state", b_state, 0);

      // Round-robin with all three holding reads: 0,1,2,0,1,2.
      a_busy_len = 2; a_cart_data = 8'h5A;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 3; i++) begin
            a_exp_strobe(1'b0, 1'b1, 16'h1000 + 16'(i), 8'h00);
            a_exp_ack(3'b000, 3'(1 << i), 8'h5A);
         end
      end
      for (int i = 0; i < 3; i++) a_req(2'(i), 1'b1, 1'b0, 16'h1000 + 16'(i), 8'h00);
      got = 0;
      for (int k = 0; k < 200 && got < 6; k++) begin
         @(negedge clk_8m);
         if (|a.req_ack) got++;
      end
      a.req_rd = '0;
      check("rr_ack_count", got, 6);
      check("rr_strobe_gap", a_last_sc - a_prev_sc, 5);

      // Fixed priority with all three holding reads: 0,0,0.
      b_busy_len = 2; b_cart_data = 8'hB7;
      for (int k = 0; k < 3; k++) begin
         b_sq.push_back({1'b0, 1'b1, 16'h1000, 8'h00});
         b_aq.push_back({3'b000, 3'b001, 8'hB7});
      end
      for (int i = 0; i < 3; i++) b_req(2'(i), 1'b1, 16'h1000 + 16'(i));
      got = 0;
      for (int k = 0; k < 200 && got < 3; k++) begin
         @(negedge clk_8m);
         if (|b.req_ack) got++;
      end
      b.req_rd = '0;
      check("fp_ack_count", got, 3);

      // Single read: req0 at 0x0150, busy 4 cycles, data 0xC3.
      do_reset();
      a_busy_len = 4; a_cart_data = 8'hC3;
      a_exp_strobe(1'b0, 1'b1, 16'h0150, 8'h3C);
      a_exp_ack(3'b000, 3'b001, 8'hC3);
      a_req(2'd0, 1'b1, 1'b0, 16'h0150, 8'h3C);
      wait_a_ack(2'd0, 30, "rd_ack");
      a.req_rd[0] = 1'b0;
      check("rd_latency", cyc - a_last_sc, 6);
      check("rd_dout", a.req_dout, 8'hC3);

      // Write wins when rd and wr are both high; read data is left untouched.
      a_busy_len = 3; a_cart_data = 8'h99;
      a_exp_strobe(1'b1, 1'b0, 16'h2000, 8'h05);
      a_exp_ack(3'b000, 3'b010, 8'hC3);
      a_req(2'd1, 1'b1, 1'b1, 16'h2000, 8'h05);
      wait_a_ack(2'd1, 30, "wr_ack");
      a.req_rd[1] = 1'b0; a.req_wr[1] = 1'b0;
      @(negedge clk_8m);
      check("wr_dout_hold", a.req_dout, 8'hC3);
      check("wr_addr_hold", a.cart_addr, 16'h2000);
      check("wr_din_hold", a.cart_din, 8'h05);

      // Force req1 with req0 also pending; dropping force mid-transaction must not abort it.
      a_cart_data = 8'h77;
      a.force_en = 1'b1; a.force_sel = 3'd1;
      a_exp_strobe(1'b0, 1'b1, 16'h3001, 8'h05);
      a_exp_ack(3'b000, 3'b010, 8'h77);
      a_exp_strobe(1'b0, 1'b1, 16'h3000, 8'h3C);
      a_exp_ack(3'b000, 3'b001, 8'h78);
      a_req(2'd0, 1'b1, 1'b0, 16'h3000, 8'h3C);
      a_req(2'd1, 1'b1, 1'b0, 16'h3001, 8'h05);
      wait_a_strobe(10, "force_strobe");
      a.force_en = 1'b0;
      wait_a_ack(2'd1, 30, "force_ack1");
      a.req_rd[1] = 1'b0;
      a_cart_data = 8'h78;
      wait_a_ack(2'd0, 30, "force_ack0");
      a.req_rd[0] = 1'b0;

      // force_sel == NUM_REQ leaves nobody eligible.
      a_stuck = 1'b1;
      a.force_en = 1'b1; a.force_sel = 3'd3;
      a_req(2'd2, 1'b1, 1'b0, 16'h4000, 8'h11);
      repeat (8) @(negedge clk_8m);
      check("force_oob_idle", a_state, 0);

      // Timeout: busy never rises, ack+err 10 cycles after entering WAIT_BUSY.
      a_exp_strobe(1'b0, 1'b1, 16'h4000, 8'h11);
      a_exp_ack(3'b100, 3'b100, 8'h78);
      a.force_en = 1'b0; a.force_sel = 3'd0;
      wait_a_state(2'd2, 10, "to_wait_busy");
      wb_cyc = cyc;
      wait_a_ack(2'd2, 30, "to_ack");
      a.req_rd[2] = 1'b0;
      check("to_delay", cyc - wb_cyc, 10);
      check("to_state_idle", a_state, 0);
      a_stuck = 1'b0;
      repeat (3) @(negedge clk_8m);

      // Reset while in WAIT_DONE: no ack for the aborted read, req0 wins afterwards.
      a_busy_len = 6; a_cart_data = 8'hE1;
      a_exp_strobe(1'b0, 1'b1, 16'h5000, 8'h00);
      a_req(2'd0, 1'b1, 1'b0, 16'h5000, 8'h00);
      wait_a_state(2'd3, 20, "rst_wait_done");
      rst = 1'b1;
      a.req_rd[0] = 1'b0;
      @(posedge clk_8m);
      #1 rst = 1'b0;
      @(negedge clk_8m);
      check_a_reset("rst1");
      repeat (12) @(negedge clk_8m);
      a_busy_len = 2; a_cart_data = 8'h42;
      a_exp_strobe(1'b0, 1'b1, 16'h6000, 8'h00);
      a_exp_ack(3'b000, 3'b001, 8'h42);
      a_exp_strobe(1'b0, 1'b1, 16'h6001, 8'h00);
      a_exp_ack(3'b000, 3'b010, 8'h42);
      a_req(2'd0, 1'b1, 1'b0, 16'h6000, 8'h00);
      a_req(2'd1, 1'b1, 1'b0, 16'h6001, 8'h00);
      wait_a_ack(2'd0, 30, "post_rst_ack0");
      a.req_rd[0] = 1'b0;
      wait_a_ack(2'd1, 30, "post_rst_ack1");
      a.req_rd[1] = 1'b0;
      repeat (4) @(negedge clk_8m);

      check("a_strobe_q_left", a_sq.size(), 0);
      check("a_ack_q_left", a_aq.size(), 0);
      check("b_strobe_q_left", b_sq.size(), 0);
      check("b_ack_q_left", b_aq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
